phy_tx_multilane: RTL

PHY_TX_MULTILANE -- requirements
Module: phy_tx_multilane

---
 rtl/phy_tx_multilane.sv | 93 +++++++++
 1 files changed

// File: rtl/phy_tx_multilane.sv
// Multi-lane serial transmitter: a word FIFO feeds per-lane staging registers, which
// load 32-bit shift registers once per frame. Each lane sends its word MSB first.
module phy_tx_multilane #(
  parameter int          LANES    = 2,
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  IDLE_SYM = 8'hBC
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [31:0]      data_input,
  input  logic             valid,
  input  logic             active,
  output logic             ready,
  output logic             overflow,
  output logic [LANES-1:0] data_out,
  output logic [LANES-1:0] lane_valid,
  output logic             frame_start
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [4:0]  LAST_STAGE = 5'(LANES - 1);
  localparam logic [31:0] IDLE_WORD  = {4{IDLE_SYM}};

  logic [4:0]       bit_cnt;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [31:0]      stage_q [LANES];
  logic [LANES-1:0] stage_vld;
  logic [31:0]      shift_q [LANES];
  logic             push;
  logic             pop;

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign ready       = count < FULL_COUNT;
  assign push        = valid && ready;
  assign overflow    = valid && !ready;
  assign pop         = (bit_cnt <= LAST_STAGE) && active && (count != '0);
  assign frame_start = (bit_cnt == 5'd0);

  always_comb begin
    data_out = '0;
    for (int k = 0; k < LANES; k++) data_out[k] = shift_q[k][31];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      bit_cnt <= bit_cnt + 5'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; pointers and occupancy alone decide which entries are live.
  always_ff @(posedge clk_32f) begin
    if (push) mem[wr_ptr] <= data_input;
  end

  // Lane k stages its word at bit_cnt == k; all lanes reload together at bit 31.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        stage_q[k] <= IDLE_WORD;
        shift_q[k] <= IDLE_WORD;
      end
      stage_vld  <= '0;
      lane_valid <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (bit_cnt == 5'(k)) begin
          stage_q[k]   <= pop ? mem[rd_ptr] : IDLE_WORD;
          stage_vld[k] <= pop;
        end
        shift_q[k] <= (bit_cnt == 5'd31) ? stage_q[k] : {shift_q[k][30:0], 1'b0};
      end
      if (bit_cnt == 5'd31) lane_valid <= stage_vld;
    end
  end

endmodule
